// File: rtl/systolic_feed_ctrl_pkg.sv
// rtl/systolic_feed_ctrl_pkg.sv - shared types, defaults and helpers for the systolic feed sequencer
package systolic_pkg;

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  localparam int DEF_N      = 2;
  localparam int DEF_ADDR_W = 4;
  // Wide enough for t up to K+N-2 with K up to 2^ADDR_W and the drain count
  localparam int CNT_W      = 8;

  // Lane i carries operand word (t - i) while 0 <= t - i < k
  function automatic logic lane_active(input logic [CNT_W-1:0] t, input int i, input int k);
    return (int'(t) >= i) && (int'(t) < i + k);
  endfunction

endpackage

// File: rtl/systolic_feed_ctrl_if.sv
// rtl/systolic_feed_ctrl_if.sv - start/status and RAM-read bundle between sequencer and array
interface systolic_feed_ctrl_if
  import systolic_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic                start;
  logic                busy;
  logic                done;
  logic [N-1:0]        a_en;
  logic [N*ADDR_W-1:0] a_addr;
  logic [N-1:0]        b_en;
  logic [N*ADDR_W-1:0] b_addr;
  logic [N-1:0]        lane_vld;
  logic                pe_clr;
  logic                pe_en;

  // Sequencer side
  modport master (
    input  start,
    output busy, done, a_en, a_addr, b_en, b_addr, lane_vld, pe_clr, pe_en
  );

  // Requester / array side
  modport slave (
    output start,
    input  busy, done, a_en, a_addr, b_en, b_addr, lane_vld, pe_clr, pe_en
  );

endinterface

// File: rtl/systolic_feed_ctrl_lane_gen.sv
// rtl/systolic_feed_ctrl_lane_gen.sv - per-lane RAM enable and skewed read address
module feed_lane_gen
  import systolic_pkg::*;
#(
  parameter int LANE   = 0,
  parameter int K      = 3,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              feed,
  input  logic [CNT_W-1:0]  t,
  output logic              en,
  output logic [ADDR_W-1:0] addr
);

  // Word offset within the lane; wraps modulo the RAM depth
  logic [ADDR_W-1:0] offs;
  assign offs = t[ADDR_W-1:0] - ADDR_W'(LANE);

  // Register en/addr for the upcoming cycle; address holds while the lane is idle
  always_ff @(posedge clk) begin
    if (rst) begin
      en   <= 1'b0;
      addr <= '0;
    end else if (feed && lane_active(t, LANE, K)) begin
      en   <= 1'b1;
      addr <= ADDR_W'(BASE) + offs;
    end else begin
      en   <= 1'b0;
    end
  end

endmodule

// File: rtl/systolic_feed_ctrl.sv
// rtl/systolic_feed_ctrl.sv - skewed operand feed sequencer for an NxN systolic array
module systolic_feed_ctrl
  import systolic_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int K      = 3,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int A_BASE = 0,
  parameter int B_BASE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  systolic_feed_ctrl_if.master  bus
);

  // Last feed step and last drain step (drain covers RAM latency plus PE skew)
  localparam logic [CNT_W-1:0] T_LAST = CNT_W'(K + N - 2);
  localparam logic [CNT_W-1:0] D_LAST = CNT_W'(2 * N - 1);

  state_t             state;
  logic [CNT_W-1:0]   t;
  logic [CNT_W-1:0]   d;
  logic               feed_nxt;
  logic [CNT_W-1:0]   t_nxt;
  logic [N-1:0]       a_en_w;
  logic [N-1:0]       b_en_w;
  logic [N*ADDR_W-1:0] a_addr_w;
  logic [N*ADDR_W-1:0] b_addr_w;

  // Lane generators register their outputs for the step the FSM is entering,
  // so en/addr line up with state and t in the same cycle.
  assign feed_nxt = (state == IDLE && bus.start) || (state == FEED && t != T_LAST);
  assign t_nxt    = (state == FEED) ? t + CNT_W'(1) : '0;

  for (genvar g = 0; g < N; g++) begin : g_lane
    feed_lane_gen #(.LANE(g), .K(K), .ADDR_W(ADDR_W), .BASE(A_BASE)) u_a (
      .clk  (clk),
      .rst  (rst),
      .feed (feed_nxt),
      .t    (t_nxt),
      .en   (a_en_w[g]),
      .addr (a_addr_w[g*ADDR_W +: ADDR_W])
    );
    feed_lane_gen #(.LANE(g), .K(K), .ADDR_W(ADDR_W), .BASE(B_BASE)) u_b (
      .clk  (clk),
      .rst  (rst),
      .feed (feed_nxt),
      .t    (t_nxt),
      .en   (b_en_w[g]),
      .addr (b_addr_w[g*ADDR_W +: ADDR_W])
    );
  end

  assign bus.a_en   = a_en_w;
  assign bus.b_en   = b_en_w;
  assign bus.a_addr = a_addr_w;
  assign bus.b_addr = b_addr_w;

  // Pass sequencing: IDLE -> FEED -> DRAIN -> DONE, with registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      t          <= '0;
      d          <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.pe_clr <= 1'b0;
      bus.pe_en  <= 1'b0;
    end else begin
      bus.pe_clr <= 1'b0;
      bus.done   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state      <= FEED;
            t          <= '0;
            bus.pe_clr <= 1'b1;
            bus.busy   <= 1'b1;
            bus.pe_en  <= 1'b1;
          end
        end
        FEED: begin
          if (t == T_LAST) begin
            state <= DRAIN;
            d     <= '0;
          end else begin
            t <= t + CNT_W'(1);
          end
        end
        DRAIN: begin
          if (d == D_LAST) begin
            state     <= DONE;
            bus.pe_en <= 1'b0;
            bus.done  <= 1'b1;
          end else begin
            d <= d + CNT_W'(1);
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM read data appears one cycle after its enable
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.lane_vld <= '0;
    end else begin
      bus.lane_vld <= a_en_w;
    end
  end

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// tb/tb_systolic_feed_ctrl.sv - randomized model-checked bench for systolic_feed_ctrl
module tb_systolic_feed_ctrl;

  localparam int NI = 4;
  localparam int N  = 2;

  // Per-instance configuration: K, A_BASE, B_BASE
  int kk[NI] = '{3, 3, 1, 2};
  int ab[NI] = '{0, 14, 0, 0};
  int bb[NI] = '{0, 0, 5, 0};

  logic clk;
  logic rst;
  logic start;

  int n_checks = 0;
  int n_errors = 0;

  systolic_feed_ctrl_if #(.N(2), .ADDR_W(4)) if0 ();
  systolic_feed_ctrl_if #(.N(2), .ADDR_W(4)) if1 ();
  systolic_feed_ctrl_if #(.N(2), .ADDR_W(4)) if2 ();
  systolic_feed_ctrl_if #(.N(2), .ADDR_W(4)) if3 ();

  assign if0.start = start;
  assign if1.start = start;
  assign if2.start = start;
  assign if3.start = start;

  systolic_feed_ctrl #(.N(2), .K(3), .ADDR_W(4), .A_BASE(0),  .B_BASE(0)) u0 (.clk(clk), .rst(rst), .bus(if0.master));
  systolic_feed_ctrl #(.N(2), .K(3), .ADDR_W(4), .A_BASE(14), .B_BASE(0)) u1 (.clk(clk), .rst(rst), .bus(if1.master));
  systolic_feed_ctrl #(.N(2), .K(1), .ADDR_W(4), .A_BASE(0),  .B_BASE(5)) u2 (.clk(clk), .rst(rst), .bus(if2.master));
  systolic_feed_ctrl #(.N(2), .K(2), .ADDR_W(4), .A_BASE(0),  .B_BASE(0)) u3 (.clk(clk), .rst(rst), .bus(if3.master));

  // {busy, done, pe_clr, pe_en, a_en, b_en, lane_vld, a_addr, b_addr}
  logic [25:0] obs[NI];
  assign obs[0] = {if0.busy, if0.done, if0.pe_clr, if0.pe_en, if0.a_en, if0.b_en, if0.lane_vld, if0.a_addr, if0.b_addr};
  assign obs[1] = {if1.busy, if1.done, if1.pe_clr, if1.pe_en, if1.a_en, if1.b_en, if1.lane_vld, if1.a_addr, if1.b_addr};
  assign obs[2] = {if2.busy, if2.done, if2.pe_clr, if2.pe_en, if2.a_en, if2.b_en, if2.lane_vld, if2.a_addr, if2.b_addr};
  assign obs[3] = {if3.busy, if3.done, if3.pe_clr, if3.pe_en, if3.a_en, if3.b_en, if3.lane_vld, if3.a_addr, if3.b_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: cycles elapsed since accept (0 = idle), plus per-lane state
  int         ph[NI];
  logic [1:0] en_m[NI];
  logic [1:0] vld_m[NI];
  logic [3:0] ha[NI][2];
  logic [3:0] hb[NI][2];

  // RAM and array model for the K=2 instance
  int         ram_a[2][16];
  int         ram_b[2][16];
  int         do_a[2];
  int         do_b[2];
  logic [1:0] cap_en;
  logic [7:0] cap_a_addr;
  logic [7:0] cap_b_addr;
  int         qa[2][$];
  int         qb[2][$];
  int         cexp[2][2] = '{'{19, 22}, '{43, 50}};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step_model(input bit r, input bit s);
    for (int i = 0; i < NI; i++) begin
      if (r) begin
        ph[i]    = 0;
        en_m[i]  = '0;
        vld_m[i] = '0;
        for (int l = 0; l < 2; l++) begin
          ha[i][l] = '0;
          hb[i][l] = '0;
        end
      end else begin
        vld_m[i] = en_m[i];
        if (ph[i] == 0) ph[i] = s ? 1 : 0;
        else if (ph[i] == kk[i] + 3 * N) ph[i] = 0;
        else ph[i] = ph[i] + 1;
        for (int l = 0; l < 2; l++) begin
          int t;
          t = ph[i] - 1;
          en_m[i][l] = (ph[i] >= 1) && (ph[i] <= kk[i] + N - 1) && (t >= l) && (t < l + kk[i]);
          if (en_m[i][l]) begin
            ha[i][l] = 4'(ab[i] + t - l);
            hb[i][l] = 4'(bb[i] + t - l);
          end
        end
      end
    end
  endtask

  function automatic logic [25:0] exp_vec(input int i);
    return {ph[i] >= 1, ph[i] == kk[i] + 3 * N, ph[i] == 1,
            (ph[i] >= 1) && (ph[i] <= kk[i] + 3 * N - 1),
            en_m[i], en_m[i], vld_m[i], ha[i][1], ha[i][0], hb[i][1], hb[i][0]};
  endfunction

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      logic [25:0] e;
      e = exp_vec(i);
      check_val($sformatf("u%0d busy", i),     32'(obs[i][25]),    32'(e[25]));
      check_val($sformatf("u%0d done", i),     32'(obs[i][24]),    32'(e[24]));
      check_val($sformatf("u%0d pe_clr", i),   32'(obs[i][23]),    32'(e[23]));
      check_val($sformatf("u%0d pe_en", i),    32'(obs[i][22]),    32'(e[22]));
      check_val($sformatf("u%0d a_en", i),     32'(obs[i][21:20]), 32'(e[21:20]));
      check_val($sformatf("u%0d b_en", i),     32'(obs[i][19:18]), 32'(e[19:18]));
      check_val($sformatf("u%0d lane_vld", i), 32'(obs[i][17:16]), 32'(e[17:16]));
      check_val($sformatf("u%0d a_addr", i),   32'(obs[i][15:8]),  32'(e[15:8]));
      check_val($sformatf("u%0d b_addr", i),   32'(obs[i][7:0]),   32'(e[7:0]));
    end
  endtask

  task automatic score();
    check_val("sb qa0 len", 32'(qa[0].size()), 32'd2);
    check_val("sb qa1 len", 32'(qa[1].size()), 32'd2);
    check_val("sb qb0 len", 32'(qb[0].size()), 32'd2);
    check_val("sb qb1 len", 32'(qb[1].size()), 32'd2);
    if (qa[0].size() == 2 && qa[1].size() == 2 && qb[0].size() == 2 && qb[1].size() == 2) begin
      for (int i = 0; i < 2; i++) begin
        for (int j = 0; j < 2; j++) begin
          int c;
          c = 0;
          for (int k = 0; k < 2; k++) c += qa[i][k] * qb[j][k];
          check_val($sformatf("sb c%0d%0d", i, j), 32'(c), 32'(cexp[i][j]));
        end
      end
    end
    for (int l = 0; l < 2; l++) begin
      qa[l].delete();
      qb[l].delete();
    end
  endtask

  task automatic cycle(input bit r, input bit s);
    rst        = r;
    start      = s;
    cap_en     = if3.a_en;
    cap_a_addr = if3.a_addr;
    cap_b_addr = if3.b_addr;
    @(posedge clk);
    step_model(r, s);
    for (int l = 0; l < 2; l++) begin
      if (cap_en[l]) begin
        do_a[l] = ram_a[l][cap_a_addr[l*4 +: 4]];
        do_b[l] = ram_b[l][cap_b_addr[l*4 +: 4]];
      end
    end
    @(negedge clk);
    check_all();
    if (r) begin
      for (int l = 0; l < 2; l++) begin
        qa[l].delete();
        qb[l].delete();
      end
    end else begin
      for (int l = 0; l < 2; l++) begin
        if (if3.lane_vld[l]) begin
          qa[l].push_back(do_a[l]);
          qb[l].push_back(do_b[l]);
        end
      end
      if (if3.done) score();
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    for (int l = 0; l < 2; l++) begin
      do_a[l] = 0;
      do_b[l] = 0;
      for (int a = 0; a < 16; a++) begin
        ram_a[l][a] = 100 + a + 16 * l;
        ram_b[l][a] = 200 + a + 16 * l;
      end
    end
    // A = [1 2; 3 4] by row lane, B = [5 6; 7 8] by column lane
    ram_a[0][0] = 1; ram_a[0][1] = 2;
    ram_a[1][0] = 3; ram_a[1][1] = 4;
    ram_b[0][0] = 5; ram_b[0][1] = 7;
    ram_b[1][0] = 6; ram_b[1][1] = 8;

    repeat (3) cycle(1'b1, 1'b0);
    repeat (2) cycle(1'b0, 1'b0);

    // Reset held for 3 cycles in the middle of FEED
    cycle(1'b0, 1'b1);
    repeat (2) cycle(1'b0, 1'b0);
    repeat (3) cycle(1'b1, 1'b0);
    repeat (2) cycle(1'b0, 1'b0);

    // Full pass with stray starts at c3 and in the DONE cycle, then a second pass at c10
    cycle(1'b0, 1'b1);
    for (int c = 1; c <= 9; c++) cycle(1'b0, (c == 3) || (c == 9));
    cycle(1'b0, 1'b1);
    repeat (12) cycle(1'b0, 1'b0);

    // Randomized starts and occasional resets
    for (int n = 0; n < 600; n++) begin
      bit r;
      bit s;
      r = ($urandom % 70) == 0;
      s = ($urandom % 4) == 0;
      cycle(r, s);
    end
    repeat (20) cycle(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
